// File: rtl/ps2_key_ctrl_if.sv
// FIFO-side handshake between ps2_keyboard and ps2_key_ctrl.
// master: the FIFO owner (drives head byte, ready, overflow).
// slave:  the consumer (drives the active-low pop strobe).
interface ps2_key_ctrl_if;
  logic [7:0] ps2_data;
  logic       ps2_ready;
  logic       ps2_overflow;
  logic       nextdata_n;

  modport master (
    output ps2_data,
    output ps2_ready,
    output ps2_overflow,
    input  nextdata_n
  );

  modport slave (
    input  ps2_data,
    input  ps2_ready,
    input  ps2_overflow,
    output nextdata_n
  );
endinterface

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: drains the ps2_keyboard FIFO one byte per three cycles and
// turns PS/2 set-2 scan codes (E0 extended / F0 break prefixes) into
// single-cycle key events, tracks the held key, counts distinct presses and
// keeps a sticky error flag for FIFO overflow and doubled prefixes.
// Optional feature macro: PS2_KEY_CTRL_EXT_EN enables E0 (extended) handling;
// without it E0 bytes are popped and dropped and key_ext is always 0.
module ps2_key_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  ps2_key_ctrl_if.slave    ps2,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_break,
  output logic             key_repeat,
  output logic             key_down,
  output logic [7:0]       hold_code,
  output logic [CNT_W-1:0] press_cnt,
  output logic             err
);

`ifdef PS2_KEY_CTRL_EXT_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_ACK  = 8'hFA;
  localparam logic [7:0] SC_BAT  = 8'hAA;
  localparam logic [7:0] SC_ECHO = 8'hEE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       accept;
  logic       nextdata_n_q;

  logic       ext_pend_q;
  logic       brk_pend_q;
  logic       hold_ext_q;

  logic [7:0] rx_byte;
  logic       is_ext_pfx;
  logic       is_brk_pfx;
  logic       is_silent;
  logic       is_event;
  logic       ev_ext;
  logic       hold_match;
  logic       dbl_pfx;
  logic       new_press;
  logic       take_event;

  // State register; reset forces IDLE from any state, including mid-POP.
  always_ff @(posedge clk) begin
    if (!clrn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: a byte is accepted only from IDLE; POP and SETTLE
  // ignore ps2_ready so the FIFO gets a cycle to update after each pop.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ps2.ps2_ready) begin
          accept  = 1'b1;
          state_d = POP;
        end
      end
      POP:     state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Byte classification. The head byte is decoded on the accepting edge so
  // the event and the pop strobe appear together in the POP cycle.
  always_comb begin
    rx_byte    = ps2.ps2_data;
    is_ext_pfx = (rx_byte == SC_EXT);
    is_brk_pfx = (rx_byte == SC_BRK);
    is_silent  = !(ext_pend_q || brk_pend_q) &&
                 ((rx_byte == SC_ACK) || (rx_byte == SC_BAT) || (rx_byte == SC_ECHO));
    is_event   = !is_ext_pfx && !is_brk_pfx && !is_silent;
    ev_ext     = EXT_EN & ext_pend_q;
    hold_match = key_down && (rx_byte == hold_code) && (ev_ext == hold_ext_q);
    dbl_pfx    = (EXT_EN && is_ext_pfx && ext_pend_q) || (is_brk_pfx && brk_pend_q);
    take_event = accept && is_event;
    new_press  = take_event && !brk_pend_q && !hold_match;
  end

  assign ps2.nextdata_n = nextdata_n_q;

  // Pop strobe: registered, low for exactly the POP cycle.
  always_ff @(posedge clk) begin
    if (!clrn) nextdata_n_q <= 1'b1;
    else       nextdata_n_q <= !accept;
  end

  // Prefix state carried between bytes; any event clears both flags.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
    end else if (accept) begin
      if (is_ext_pfx) begin
        ext_pend_q <= EXT_EN;
      end else if (is_brk_pfx) begin
        brk_pend_q <= 1'b1;
      end else if (is_event) begin
        ext_pend_q <= 1'b0;
        brk_pend_q <= 1'b0;
      end
    end
  end

  // Sticky error: FIFO overflow on any cycle or a repeated prefix byte.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      err <= 1'b0;
    end else if (ps2.ps2_overflow || (accept && dbl_pfx)) begin
      err <= 1'b1;
    end
  end

  // Event presentation: key_valid pulses, the key_* fields hold until the
  // next event.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      key_valid  <= 1'b0;
      key_code   <= '0;
      key_ext    <= 1'b0;
      key_break  <= 1'b0;
      key_repeat <= 1'b0;
    end else begin
      key_valid <= take_event;
      if (take_event) begin
        key_code   <= rx_byte;
        key_ext    <= ev_ext;
        key_break  <= brk_pend_q;
        key_repeat <= !brk_pend_q && hold_match;
      end
    end
  end

  // Held-key tracking: a fresh make captures (code, ext); only a break of
  // that same key releases it, and hold_code keeps its last value.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      key_down   <= 1'b0;
      hold_code  <= '0;
      hold_ext_q <= 1'b0;
    end else if (new_press) begin
      key_down   <= 1'b1;
      hold_code  <= rx_byte;
      hold_ext_q <= ev_ext;
    end else if (take_event && brk_pend_q && hold_match) begin
      key_down   <= 1'b0;
    end
  end

  // Distinct-press counter; typematic repeats do not count. Wraps.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      press_cnt <= '0;
    end else if (new_press) begin
      press_cnt <= press_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/ps2_key_ctrl.md
# ps2_key_ctrl

Scan-code controller sitting directly after `ps2_keyboard`. It drains that block's receive FIFO through the `ready` / `nextdata_n` handshake and decodes PS/2 set-2 prefix sequences (`E0` extended, `F0` break) into single-cycle key events. It also tracks the currently held key, counts distinct key presses, and flags FIFO overflow and malformed sequences. Its outputs feed display/ASCII logic in `top`.

## Interface
Parameters:
- `CNT_W`, default 8: width of the press counter.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `clrn`  in  1  reset; synchronous, active-low.
- `ps2_data`  in  8  FIFO head byte from `ps2_keyboard` (`data`).
- `ps2_ready`  in  1  FIFO non-empty, from `ps2_keyboard` (`ready`).
- `ps2_overflow`  in  1  FIFO overflow indication, from `ps2_keyboard`.
- `nextdata_n`  out  1  active-low pop strobe to `ps2_keyboard`.
- `key_valid`  out  1  one-cycle pulse: a key event is presented on the `key_*` outputs.
- `key_code`  out  8  scan code of the event.
- `key_ext`  out  1  event was `E0`-prefixed.
- `key_break`  out  1  event is a release (`F0`-prefixed).
- `key_repeat`  out  1  event is a typematic repeat of the held key.
- `key_down`  out  1  level: a key is currently held.
- `hold_code`  out  8  code of the held key.
- `press_cnt`  out  `CNT_W`  number of distinct make events; wraps.
- `err`  out  1  sticky error flag.

## Operation
- FSM states: IDLE, POP, SETTLE.
  - IDLE: when `ps2_ready`=1, latch `ps2_data` and go to POP.
  - POP: `nextdata_n`=0 for this cycle only; the latched byte is decoded and the outputs update; go to SETTLE.
  - SETTLE: `nextdata_n`=1; unconditionally return to IDLE. This gives `ps2_keyboard` one cycle to update `ready`.
- Pending flags `ext_pend` and `brk_pend` hold prefix state between bytes.
- Decode of the latched byte b:
  - `E0`: set `ext_pend`; no event. If `ext_pend` was already set, set `err` as well.
  - `F0`: set `brk_pend`; no event. If `brk_pend` was already set, set `err` as well.
  - `FA`, `AA` or `EE` with no prefix pending: consumed silently; no event.
  - Any other byte is an event:
    - `key_valid`=1, `key_code`=b, `key_ext`=`ext_pend`, `key_break`=`brk_pend`.
    - Both pending flags clear.
- Make event (`brk_pend`=0):
  - If `key_down`=1 and (b, ext) equals the held (`hold_code`, hold_ext): `key_repeat`=1; `press_cnt` is unchanged.
  - Otherwise: `key_repeat`=0, `press_cnt`+1 (modulo 2^`CNT_W`), `key_down`=1, and (b, ext) is captured as the held key.
- Break event: if (b, ext) equals the held key, `key_down` clears; `hold_code` keeps its last value. A break for any other key leaves the held key unchanged. `key_repeat`=0.
- `err` is set by `ps2_overflow`=1 on any cycle, or by a doubled prefix. It clears only on reset.

## Timing
- Reset (`clrn`=0 at an edge):
  - State returns to IDLE from any state, including mid-POP.
  - `nextdata_n`=1; `key_valid`, `key_ext`, `key_break`, `key_repeat`, `key_down` = 0.
  - `key_code`, `hold_code`, `press_cnt` = 0; `err`=0; pending flags cleared.
- Latency: `ps2_ready` seen high in IDLE at edge N → `nextdata_n` low and `key_valid` high together during cycle N+1 (both registered).
- Throughput: at most one byte per 3 cycles. This is ample for PS/2 line rate.
- `ps2_ready` is ignored in POP and SETTLE. Exactly one pop occurs per accepted byte; there is never a pop while the FIFO is empty.
- `key_*` fields hold their values until the next event; only `key_valid` is pulsed.
- Overflow in the same cycle as a pop: the byte is still decoded normally and `err` sets.

## Configuration
- `PS2_KEY_CTRL_EXT_EN` defined: `E0` handling exactly as in Operation.
- Not defined:
  - `E0` bytes are popped and discarded, with no flag and no error.
  - `key_ext` and the held-ext comparison are tied to 0.
  - Extended keys alias their non-extended codes.

## Test plan
- Reset: hold `clrn`=0 for 2 cycles with `ps2_ready`=1 → `nextdata_n`=1, all outputs 0, no pop.
- Byte `1C`: `nextdata_n` is low exactly one cycle (N+1), coincident with `key_valid`; `key_code`=`1C`, `key_break`=0, `press_cnt`=1, `key_down`=1, `hold_code`=`1C`.
- Sequence `1C`,`1C`,`F0`,`1C` → three events: make; repeat (`key_repeat`=1, `press_cnt` stays 1); break (`key_down`=0). No event for `F0`.
- With the macro: `E0` `75` `E0` `F0` `75` → make with `key_ext`=1, code `75`; then break with `key_ext`=1. `press_cnt`+1. Without the macro: the same stimulus gives `key_ext`=0 on both events.
- `F0` `F0` `1C` → `err`=1 and a single break event with code `1C`. Separately, pulse `ps2_overflow` for 1 cycle → `err`=1, which persists until `clrn`=0.
- `CNT_W`=2: four make/break pairs on distinct codes → `press_cnt` reads 1, 2, 3, 0. `FA` and `AA` bytes interleaved between the pairs produce no events.
